// File: rtl/rgb_pwm_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pkg
// Shared definitions for the RGB PWM colour sequencer.
//   DEFAULT_PWM_BITS / DEFAULT_STEPS : default parameter values used by the
//                                      sequencer, its channel and its bus.
//   duty_t                           : duty word at the default resolution.
//   lerp()                           : linear interpolation used when the
//                                      RGB_SEQ_FADE_EN crossfade is compiled in.
// ---------------------------------------------------------------------------
package rgb_pkg;

    localparam int DEFAULT_PWM_BITS = 8;
    localparam int DEFAULT_STEPS    = 4;

    typedef logic [DEFAULT_PWM_BITS-1:0] duty_t;

    // Interpolates from a towards b by frac / 2^frac_bits, rounding towards
    // minus infinity through the arithmetic shift. The difference and the
    // product need PWM_BITS+HOLD_LOG2+1 signed bits at most, so a 32-bit
    // signed int gives bit-identical results for any sensible configuration.
    // Because frac < 2^frac_bits the result always lies between a and b, so
    // the caller can truncate it back to the duty width without loss.
    function automatic int lerp(input int a, input int b, input int frac, input int frac_bits);
        int diff;
        int prod;
        diff = b - a;
        prod = diff * frac;
        return a + (prod >>> frac_bits);
    endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_if.sv
// ---------------------------------------------------------------------------
// rgb_pwm_sequencer_if
// Palette configuration bus of the RGB PWM sequencer.
//   cfg_we   : palette write strobe, one entry per cycle it is high.
//   cfg_addr : palette entry index ($clog2(STEPS) bits).
//   cfg_data : duties of all channels, channel c at [c*PWM_BITS +: PWM_BITS].
// Modports: master drives the bus (host / testbench), slave is the sequencer.
// ---------------------------------------------------------------------------
interface rgb_pwm_sequencer_if
    import rgb_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = DEFAULT_PWM_BITS,
    parameter int STEPS    = DEFAULT_STEPS
) ();

    localparam int ADDR_BITS = $clog2(STEPS);

    logic                         cfg_we;
    logic [ADDR_BITS-1:0]         cfg_addr;
    logic [CHANNELS*PWM_BITS-1:0] cfg_data;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_data
    );

    modport slave (
        input cfg_we,
        input cfg_addr,
        input cfg_data
    );

endinterface

// File: rtl/rgb_pwm_sequencer_channel.sv
// ---------------------------------------------------------------------------
// rgb_pwm_channel
// One PWM output of the sequencer: a duty register that only reloads at a
// period boundary, a compare against the shared period counter, and the
// registered output that feeds the RGB driver pin.
//   clk, rst    : clock and synchronous active-high reset.
//   enable      : low forces the output off on the next cycle.
//   load        : period boundary strobe, reloads duty_q from duty_target.
//   duty_target : duty the next period should use.
//   pwm_cnt     : shared period counter.
//   pwm_out     : registered PWM output.
// ---------------------------------------------------------------------------
module rgb_pwm_channel
    import rgb_pkg::*;
#(
    parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                load,
    input  logic [PWM_BITS-1:0] duty_target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] duty_q;

    // The duty register only changes on the boundary strobe. A period that
    // has already started therefore keeps its duty to the end, so a palette
    // write can never cut a high pulse short or add an extra one.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
        end else if (load) begin
            duty_q <= duty_target;
        end
    end

    // Registered compare. The output is high while the counter is below the
    // duty: duty 0 never asserts and the all-ones duty leaves exactly one low
    // tick per period. While disabled the output is forced low.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= enable && (pwm_cnt < duty_q);
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_pwm_sequencer
// Multi-channel LED colour sequencer. Steps through a palette written over
// the cfg bus and drives one PWM output per colour component, intended for
// the RGBnPWM pins of the SB_RGBA_DRV primitive.
//   clk, rst     : single clock, synchronous active-high reset.
//   enable       : run/freeze. Low freezes all counters and forces pwm_out low.
//   cfg          : palette write bus (rgb_pwm_sequencer_if.slave).
//   pwm_out      : registered PWM outputs, one per channel.
//   step_idx     : palette step currently being shown.
//   period_start : one-cycle pulse on the first pwm_out cycle of each period.
// Build option:
//   RGB_SEQ_FADE_EN : when defined, each step crossfades linearly towards the
//                     next palette entry. Undefined gives hard steps and the
//                     interpolation logic is not built.
// ---------------------------------------------------------------------------
module rgb_pwm_sequencer
    import rgb_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int PWM_BITS  = DEFAULT_PWM_BITS,
    parameter int PRESCALE  = 1,
    parameter int STEPS     = DEFAULT_STEPS,
    parameter int HOLD_LOG2 = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    rgb_pwm_sequencer_if.slave        cfg,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [$clog2(STEPS)-1:0]  step_idx,
    output logic                      period_start
);

    localparam int ADDR_BITS = $clog2(STEPS);
    localparam int PRE_BITS  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int ENTRY_W   = CHANNELS * PWM_BITS;

    localparam logic [PRE_BITS-1:0]  PRE_LAST  = PRE_BITS'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0]  PWM_MAX   = '1;
    localparam logic [HOLD_LOG2-1:0] HOLD_MAX  = '1;
    localparam logic [ADDR_BITS-1:0] STEP_LAST = ADDR_BITS'(STEPS - 1);

    logic [ENTRY_W-1:0]   palette [STEPS];

    logic [PRE_BITS-1:0]  prescaler;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [HOLD_LOG2-1:0] hold_cnt;
    logic                 pb_q;

    logic                 tick;
    logic                 pb;
    logic                 cfg_hit;
    logic [HOLD_LOG2-1:0] hold_nxt;
    logic [ADDR_BITS-1:0] step_nxt;
    logic [ENTRY_W-1:0]   entry_a;

    logic [CHANNELS-1:0][PWM_BITS-1:0] duty_target;

`ifdef RGB_SEQ_FADE_EN
    logic [ADDR_BITS-1:0] step_after;
    logic [ENTRY_W-1:0]   entry_b;
`endif

    // Timing strobes and the sequencer's next state. tick is one PWM count,
    // pb is the last tick of a period. hold_nxt/step_nxt are the values the
    // sequencer will hold once this cycle's edge has passed; the duty
    // targets are built from them so that the duty loaded at a boundary
    // belongs to the period that boundary opens. That is what makes a new
    // step visible from its very first period.
    always_comb begin
        tick     = (prescaler == PRE_LAST) && enable;
        pb       = tick && (pwm_cnt == PWM_MAX);
        hold_nxt = hold_cnt;
        step_nxt = step_idx;
        if (pb) begin
            hold_nxt = hold_cnt + HOLD_LOG2'(1);
            if (hold_cnt == HOLD_MAX) begin
                step_nxt = (step_idx == STEP_LAST) ? '0 : step_idx + ADDR_BITS'(1);
            end
        end
    end

    // Writes whose address lies beyond the last palette entry are dropped.
    // This only matters when STEPS is not a power of two.
    always_comb begin
        cfg_hit = cfg.cfg_we && (int'(cfg.cfg_addr) < STEPS);
    end

`ifdef RGB_SEQ_FADE_EN
    // The fade end point is the entry after the upcoming step, wrapping from
    // the last entry back to the first.
    always_comb begin
        step_after = (step_nxt == STEP_LAST) ? '0 : step_nxt + ADDR_BITS'(1);
        entry_b    = palette[step_after];
    end
`endif

    // Per-channel duty the next period should use. The palette is read
    // before this cycle's write lands, so a write coinciding with a boundary
    // loads the old value and the new one follows at the next boundary.
    always_comb begin
        entry_a     = palette[step_nxt];
        duty_target = '0;
        for (int c = 0; c < CHANNELS; c++) begin
`ifdef RGB_SEQ_FADE_EN
            duty_target[c] = PWM_BITS'(lerp(int'(entry_a[c*PWM_BITS +: PWM_BITS]),
                                            int'(entry_b[c*PWM_BITS +: PWM_BITS]),
                                            int'(hold_nxt), HOLD_LOG2));
`else
            duty_target[c] = entry_a[c*PWM_BITS +: PWM_BITS];
`endif
        end
    end

    // Counter chain: prescaler -> PWM period counter -> hold counter -> step.
    // Everything freezes while enable is low and resumes from where it
    // stopped. period_start is the boundary strobe delayed by two cycles:
    // one for the counter to wrap to 0 and one for the registered compare,
    // which lines it up with the first output cycle of the new period.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            hold_cnt     <= '0;
            step_idx     <= '0;
            pb_q         <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (enable) begin
                prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_BITS'(1);
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            hold_cnt     <= hold_nxt;
            step_idx     <= step_nxt;
            pb_q         <= pb;
            period_start <= pb_q;
        end
    end

    // Palette storage. Writes are accepted whether or not the sequencer is
    // running, so a host can load colours before enabling the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                palette[i] <= '0;
            end
        end else if (cfg_hit) begin
            palette[cfg.cfg_addr] <= cfg.cfg_data;
        end
    end

    // One duty register, compare and output flop per colour component, all
    // sharing the period counter and the boundary strobe.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
        rgb_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable),
            .load        (pb),
            .duty_target (duty_target[c]),
            .pwm_cnt     (pwm_cnt),
            .pwm_out     (pwm_out[c])
        );
    end

endmodule
